// File: rtl/enc_tx_packer.sv
// Packs 2-bit encoder symbols LSB-first into bytes, buffers them in a small FIFO
// and feeds a start/busy UART transmitter without losing data to back-pressure.
module enc_tx_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  input  logic [1:0]                    sym,
  input  logic                          flush,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // ---- packer stage: symbol accumulation ----
  logic [1:0] sidx;
  logic [7:0] pack;
  logic [1:0] sidx_nxt;
  logic [7:0] pack_nxt;
  logic       byte_done;
  logic       push;

  always_comb begin
    pack_nxt = pack;
    sidx_nxt = sidx;
    if (sym_valid) begin
      pack_nxt[{sidx, 1'b0} +: 2] = sym;
      sidx_nxt                    = sidx + 2'd1;
    end
  end

  // A completed byte already leaves sidx_nxt at zero, so a coincident flush adds nothing.
  assign byte_done = sym_valid && (sidx == 2'd3);
  assign push      = byte_done || (flush && (sidx_nxt != 2'd0));

  // pack is cleared after every push so a flushed partial byte is zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sidx <= 2'd0;
      pack <= 8'h00;
    end else if (push) begin
      sidx <= 2'd0;
      pack <= 8'h00;
    end else begin
      sidx <= sidx_nxt;
      pack <= pack_nxt;
    end
  end

  // ---- FIFO stage: circular buffer with wrap-bit pointers ----
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        pop;
  logic        wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A simultaneous pop frees the head slot, so a push on a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= pack_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_count = wr_ptr - rd_ptr;

  // ---- TX stage: start/busy handshake ----
  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_data is loaded on pop and holds through the whole transmitter busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= 8'h00;
    end else if (pop) begin
      tx_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_enc_tx_packer.sv
// Directed and randomized bench for enc_tx_packer with a behavioural UART model
// and a symbol-list reference model for expected byte streams.
module tb_enc_tx_packer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          sym_valid;
  logic [1:0]    sym;
  logic          flush;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  enc_tx_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .flush      (flush),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Transmitter model: busy rises right after a start pulse and lasts busy_len cycles.
  logic       hold_busy = 1'b0;
  int         busy_len  = 20;
  int         busy_cnt  = 0;
  int         n_starts  = 0;
  int         stab_err  = 0;
  int         repulse_err = 0;
  logic [7:0] held      = 8'h00;
  logic [7:0] rxq [$];

  assign tx_busy = hold_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0 && tx_data !== held) stab_err++;
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) begin
        if (tx_busy) repulse_err++;
        rxq.push_back(tx_data);
        held     = tx_data;
        n_starts++;
        busy_cnt = busy_len;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic f);
    sym_valid = v;
    sym       = s;
    flush     = f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    flush     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2], 1'b0);
  endtask

  // Reference model: symbols accumulate in a list; four symbols, or a flush with
  // any pending, form one byte whose i-th symbol has weight 4**i.
  logic [1:0] cur_syms [$];
  logic [7:0] exp_q [$];

  task automatic model_step(input logic v, input logic [1:0] s, input logic f);
    int b;
    if (v) cur_syms.push_back(s);
    if (cur_syms.size() == 4 || (f && cur_syms.size() > 0)) begin
      b = 0;
      for (int i = 0; i < cur_syms.size(); i++) b += int'(cur_syms[i]) * (4 ** i);
      exp_q.push_back(8'(b));
      cur_syms.delete();
    end
  endtask

  initial begin
    int s0;
    logic v;
    logic [1:0] s;
    logic f;

    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym       = 2'b00;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(2);

    // Single byte, latency and count trace.
    rxq.delete();
    s0 = n_starts;
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    drive(1'b1, 2'b00, 1'b0);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_no_early_start", tx_start, 0);
    idle(1);
    check("t1_start_pulse", tx_start, 1);
    check("t1_tx_data", tx_data, 8'h39);
    check("t1_count_after_pop", fifo_count, 0);
    idle(40);
    check("t1_num_starts", n_starts - s0, 1);

    // Partial byte flush, then empty flush.
    rxq.delete();
    s0 = n_starts;
    drive(1'b1, 2'b11, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b0, 2'b00, 1'b1);
    idle(40);
    check("t2_num_starts", n_starts - s0, 1);
    check("t2_flush_byte", rx_at(0), 8'h0B);
    s0 = n_starts;
    drive(1'b0, 2'b00, 1'b1);
    idle(30);
    check("t2_empty_flush", n_starts - s0, 0);

    // Flush coincident with the byte-completing symbol, then an aligned byte.
    rxq.delete();
    repeat (3) drive(1'b1, 2'b00, 1'b0);
    drive(1'b1, 2'b01, 1'b1);
    repeat (4) drive(1'b1, 2'b10, 1'b0);
    idle(70);
    check("t3_num_bytes", rxq.size(), 2);
    check("t3_byte0", rx_at(0), 8'h40);
    check("t3_byte1_aligned", rx_at(1), 8'hAA);

    // Full FIFO with simultaneous pop and push.
    rxq.delete();
    hold_busy = 1'b1;
    for (int b = 8'h10; b <= 8'h17; b++) send_byte(8'(b));
    idle(2);
    check("t5_full_count", fifo_count, 8);
    check("t5_full_no_ovf", overflow, 0);
    drive(1'b1, 2'b00, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    hold_busy = 1'b0;
    drive(1'b1, 2'b00, 1'b0);
    check("t5_count_kept", fifo_count, 8);
    check("t5_no_ovf", overflow, 0);
    idle(270);
    check("t5_num_bytes", rxq.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("t5_byte%0d", i), rx_at(i), 8'h10 + 8'(i));

    // Overflow: one byte beyond capacity is dropped.
    rxq.delete();
    hold_busy = 1'b1;
    for (int b = 0; b <= 8; b++) send_byte(8'(b));
    idle(2);
    check("t4_count", fifo_count, 8);
    check("t4_overflow", overflow, 1);
    check("t4_nothing_sent", rxq.size(), 0);
    hold_busy = 1'b0;
    idle(240);
    check("t4_num_bytes", rxq.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_byte%0d", i), rx_at(i), 8'(i));
    check("t4_overflow_sticky", overflow, 1);

    // Asynchronous reset during WAIT_DONE with three bytes buffered.
    send_byte(8'hC1);
    send_byte(8'h5A);
    send_byte(8'h7E);
    send_byte(8'h23);
    sym_valid = 1'b0;
    check("t6_buffered", fifo_count, 3);
    check("t6_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tx_start", tx_start, 0);
    check("t6_async_tx_data", tx_data, 8'h00);
    check("t6_async_count", fifo_count, 0);
    check("t6_async_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_starts;
    idle(1);
    check("t6_start_after_release", tx_start, 0);
    idle(50);
    check("t6_no_start", n_starts - s0, 0);

    // Randomized symbol stream against the reference model.
    busy_len = 3;
    rxq.delete();
    exp_q.delete();
    cur_syms.delete();
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(7) == 0);
      s = 2'($urandom_range(3));
      f = ($urandom_range(15) == 0);
      model_step(v, s, f);
      drive(v, s, f);
    end
    idle(150);
    check("rand_num_bytes", rxq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check($sformatf("rand_byte%0d", i), rx_at(i), exp_q[i]);
    check("rand_no_overflow", overflow, 0);
    check("tx_data_stable", stab_err, 0);
    check("no_repulse_while_busy", repulse_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enc_tx_packer.md
# enc_tx_packer

Downstream stage of the convolutional encoder (`encoder_sys`). It collects 2-bit encoded symbols into bytes and buffers them in a small FIFO. It then drives the UART transmitter (`async_transmitter`) through its start/busy handshake, so that encoded output streams back over USB-UART without being lost to transmitter back-pressure.

## Interface
- `FIFO_DEPTH`, 8, byte FIFO depth; power of two, ≥2
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `sym_valid`  in  1  `sym` is valid this cycle (one symbol per asserted cycle)
- `sym`  in  2  encoded symbol from encoder `out`
- `flush`  in  1  one-cycle pulse; emit a partial byte zero-padded
- `tx_busy`  in  1  transmitter busy flag
- `tx_start`  out  1  one-cycle start pulse to transmitter
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_busy` falls
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- `overflow`  out  1  sticky; set when a packed byte is dropped on full FIFO

## Operation
- Packer: 2-bit symbol index `sidx` (0..3) and 8-bit shift register `pack`.
  - On `sym_valid`, `sym` goes into `pack[2*sidx+1 : 2*sidx]`, so the first symbol lands in `[1:0]` (LSB-first, matching UART bit order).
  - `sidx` wraps 3→0. Completing the 4th symbol pushes the byte into the FIFO.
- Flush:
  - If `flush` is high and `sidx`≠0 after the current cycle's symbol is accounted for, push `pack` with unfilled positions = 0, then clear `sidx`.
  - `flush` with no partial byte is a no-op.
  - If `sym_valid` and `flush` arrive in the same cycle, the symbol is packed first. If that symbol completes a byte, exactly one byte is pushed.
- FIFO: circular, read/write pointers with one extra wrap bit.
  - Push when full is dropped and `overflow` is set. `overflow` clears only on reset.
  - Push and pop in the same cycle while full: both occur, and the count is unchanged.
  - Pop while empty never happens (the FSM guards it).
- TX FSM states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: if FIFO not empty and `tx_busy`=0, pop the head into `tx_data` register → START.
  - START: `tx_start`=1 for this single cycle → WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1 → WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy`=0 → IDLE.
- `fifo_count` = write pointer − read pointer, with pointer width one bit wider than the address.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `fifo_count`=0, `overflow`=0, FSM=IDLE, `sidx`=0, `pack`=0, pointers=0.
- Reset asserted mid-transfer: all buffered and partial data is discarded immediately. `tx_start` is low during reset and on the first cycle after release.
- Byte-completing `sym_valid` at cycle N: FIFO holds the byte at N+1. With the FSM in IDLE and `tx_busy`=0, the pop occurs at N+1, START (`tx_start`=1) at N+2, and `tx_data` is valid from N+2.
- `fifo_count` reflects a push or pop on the cycle after it occurs.
- Back-to-back bytes: minimum spacing between `tx_start` pulses is 4 cycles plus the transmitter busy time. The FSM never re-pulses while `tx_busy`=1.
- Symbol input is never back-pressured: one symbol per cycle is accepted indefinitely, and loss shows only via `overflow`.

## Test plan
- Reset, then symbols 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles; bench model asserts `tx_busy` 1 cycle after start for 20 cycles → exactly one `tx_start`, `tx_data`=8'h39, two cycles after the 4th symbol. `fifo_count` goes 1 then 0.
- Symbols 2'b11, 2'b10 then `flush` → `tx_data`=8'h0B. A second `flush` with no symbols produces no `tx_start`.
- `sym_valid` with 2'b01 and `flush` in the same cycle as the 4th symbol (prior 2'b00×3) → exactly one byte, 8'h40. `sidx` returns to 0.
- `tx_busy` held high; push `FIFO_DEPTH`+1 bytes 8'h00..8'h08 → `fifo_count`=8, `overflow`=1. After `tx_busy` releases, 8'h00..8'h07 are transmitted in order and 8'h08 is never transmitted.
- FIFO full, then a pop and a byte-completing push in the same cycle → `fifo_count` stays 8, `overflow` stays 0, and order is preserved.
- Assert `rst_n`=0 during WAIT_DONE with 3 bytes buffered → all outputs return to reset values asynchronously, and no `tx_start` occurs after release until new symbols arrive.
